// File: rtl/ptw_pkg.sv
// Shared types and constants for the two-level page-table walker.
// PTE layout: bit0 valid, bit1 leaf, bits[31:10] physical page number.
package ptw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_DONE
    } ptw_state_e;

    localparam int PTE_V       = 0;
    localparam int PTE_L       = 1;
    localparam int PTE_PPN_LSB = 10;
    localparam int PGSHIFT     = 12;

    // Zero-extended PPN field of a PTE.
    function automatic logic [31:0] pte_ppn(input logic [31:0] pte);
        return pte >> PTE_PPN_LSB;
    endfunction

endpackage

// File: rtl/ptw_pte_decode.sv
// Combinational PTE decode: descend, fault, or produce the final PPN.
// Level 0 leaves are superpages and must be aligned to the vpn_lo span.
module ptw_pte_decode
    import ptw_pkg::*;
#(
    parameter int VPN_W = 20
) (
    input  logic [31:0]        i_pte,
    input  logic               i_level,
    input  logic [VPN_W/2-1:0] i_vpn_lo,
    output logic               o_next,
    output logic               o_error,
    output logic [31:0]        o_ppn
);

    localparam int HALF = VPN_W / 2;

    logic        w_v;
    logic        w_l;
    logic        w_misal;
    logic [31:0] w_ppn;
    logic        w_unused_bits;

    assign w_v           = i_pte[PTE_V];
    assign w_l           = i_pte[PTE_L];
    assign w_ppn         = pte_ppn(i_pte);
    assign w_misal       = |w_ppn[HALF-1:0];
    assign w_unused_bits = ^i_pte[PTE_PPN_LSB-1:2];

    // Classify the PTE; any fault forces the PPN to zero.
    always_comb begin
        o_next  = 1'b0;
        o_error = 1'b0;
        o_ppn   = '0;
        if (!w_v) begin
            o_error = 1'b1;
        end else if (w_l) begin
            if (i_level) begin
                o_ppn = w_ppn;
            end else if (w_misal) begin
                o_error = 1'b1;
            end else begin
                o_ppn = {w_ppn[31:HALF], i_vpn_lo};
            end
        end else if (!i_level) begin
            o_next = 1'b1;
        end else begin
            o_error = 1'b1;
        end
    end

endmodule

// File: rtl/ptw_walker.sv
// Two-level page-table walker with a single-outstanding PTE read port.
// Each walk ends in a one-cycle response pulse toward the TLB refill port.
module ptw_walker
    import ptw_pkg::*;
#(
    parameter int VPN_W  = 20,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic [VPN_W-1:0]  io_req_bits_vpn,
    input  logic [31:0]       io_ptbr,
    output logic              io_mem_req_valid,
    input  logic              io_mem_req_ready,
    output logic [ADDR_W-1:0] io_mem_req_bits_addr,
    input  logic              io_mem_resp_valid,
    input  logic [31:0]       io_mem_resp_bits_data,
    output logic              io_resp_valid,
    output logic              io_resp_bits_error,
    output logic [31:0]       io_resp_bits_ppn
);

    localparam int HALF   = VPN_W / 2;
    localparam int FULL_W = 32 + PGSHIFT;

    ptw_state_e          r_state;
    ptw_state_e          w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [HALF-1:0]     r_vpn_lo;
    logic                r_err;
    logic [31:0]         r_ppn;

    logic [ADDR_W-1:0]   w_l0_addr;
    logic [ADDR_W-1:0]   w_l1_addr;
    logic [31:0]         w_pte_ppn;
    logic                w_level;
    logic                w_in_wait;
    logic                w_dec_next;
    logic                w_dec_err;
    logic [31:0]         w_dec_ppn;

    assign w_pte_ppn = pte_ppn(io_mem_resp_bits_data);

    assign w_l0_addr = ADDR_W'(
        {io_ptbr, {PGSHIFT{1'b0}}}
        | FULL_W'({io_req_bits_vpn[VPN_W-1:HALF], 2'b00}));

    assign w_l1_addr = ADDR_W'(
        {w_pte_ppn, {PGSHIFT{1'b0}}}
        | FULL_W'({r_vpn_lo, 2'b00}));

    assign w_level   = (r_state == ST_WAIT1);
    assign w_in_wait = (r_state == ST_WAIT0) || (r_state == ST_WAIT1);

    ptw_pte_decode #(
        .VPN_W (VPN_W)
    ) u_dec (
        .i_pte    (io_mem_resp_bits_data),
        .i_level  (w_level),
        .i_vpn_lo (r_vpn_lo),
        .o_next   (w_dec_next),
        .o_error  (w_dec_err),
        .o_ppn    (w_dec_ppn)
    );

    // State register; reset always returns to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs, all forced low during reset.
    always_comb begin
        w_next_state     = r_state;
        io_req_ready     = 1'b0;
        io_mem_req_valid = 1'b0;
        io_resp_valid    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                io_req_ready = 1'b1;
                if (io_req_valid) begin
                    w_next_state = ST_REQ0;
                end
            end
            ST_REQ0: begin
                io_mem_req_valid = 1'b1;
                if (io_mem_req_ready) begin
                    w_next_state = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (io_mem_resp_valid) begin
                    w_next_state = w_dec_next ? ST_REQ1 : ST_DONE;
                end
            end
            ST_REQ1: begin
                io_mem_req_valid = 1'b1;
                if (io_mem_req_ready) begin
                    w_next_state = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (io_mem_resp_valid) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                io_resp_valid = 1'b1;
                w_next_state  = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (reset) begin
            io_req_ready     = 1'b0;
            io_mem_req_valid = 1'b0;
            io_resp_valid    = 1'b0;
        end
    end

    // Address, vpn_lo and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= '0;
            r_vpn_lo <= '0;
            r_err    <= 1'b0;
            r_ppn    <= '0;
        end else begin
            if (r_state == ST_IDLE && io_req_valid) begin
                r_addr   <= w_l0_addr;
                r_vpn_lo <= io_req_bits_vpn[HALF-1:0];
            end
            if (w_in_wait && io_mem_resp_valid) begin
                if (w_dec_next) begin
                    r_addr <= w_l1_addr;
                end else begin
                    r_err <= w_dec_err;
                    r_ppn <= w_dec_ppn;
                end
            end
        end
    end

    assign io_mem_req_bits_addr = reset ? '0 : r_addr;
    assign io_resp_bits_error   = reset ? 1'b0 : r_err;
    assign io_resp_bits_ppn     = reset ? '0 : r_ppn;

endmodule

// File: tb/tb_ptw_walker.sv
// Directed bench for ptw_walker: one task per scenario,
// zero-wait and stalled memory, faults, and reset mid-walk.
module tb_ptw_walker;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] vpn;
    logic [31:0] ptbr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_ppn;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ptw_walker #(
        .VPN_W  (20),
        .ADDR_W (32)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .io_req_valid          (req_valid),
        .io_req_ready          (req_ready),
        .io_req_bits_vpn       (vpn),
        .io_ptbr               (ptbr),
        .io_mem_req_valid      (mem_req_valid),
        .io_mem_req_ready      (mem_req_ready),
        .io_mem_req_bits_addr  (mem_addr),
        .io_mem_resp_valid     (mem_resp_valid),
        .io_mem_resp_bits_data (mem_resp_data),
        .io_resp_valid         (resp_valid),
        .io_resp_bits_error    (resp_err),
        .io_resp_bits_ppn      (resp_ppn)
    );

    // Drives one walk from a negedge where the walker is idle.
    // Memory answers one cycle after each handshake; the first
    // read can be stalled and a stray response injected at cycle sk.
    task automatic do_walk(
        input  logic [31:0] p,
        input  logic [19:0] v,
        input  logic [31:0] l0,
        input  logic [31:0] l1,
        input  int          stall,
        input  int          sk,
        output int          lat,
        output logic        err,
        output logic [31:0] ppn,
        output logic [31:0] a0,
        output logic [31:0] a1,
        output int          nrd,
        output bit          stable,
        output bit          pulse1
    );
        bit          pend;
        logic [31:0] pdata;
        logic [31:0] cur;
        int          st;
        lat    = -1;
        err    = 1'bx;
        ppn    = 'x;
        a0     = '0;
        a1     = '0;
        nrd    = 0;
        stable = 1'b1;
        pulse1 = 1'b0;
        pend   = 1'b0;
        pdata  = '0;
        st     = stall;
        req_valid      = 1'b1;
        vpn            = v;
        ptbr           = p;
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid === 1'b1) begin
                lat = k;
                err = resp_err;
                ppn = resp_ppn;
                break;
            end
            mem_resp_valid = pend;
            mem_resp_data  = pend ? pdata : 32'h0;
            pend           = 1'b0;
            if (k == sk && !mem_resp_valid) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'h0;
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid === 1'b1) begin
                cur = mem_addr;
                if (nrd == 0) begin
                    if (st == stall) a0 = cur;
                    else if (cur !== a0) stable = 1'b0;
                end else begin
                    a1 = cur;
                end
                if (nrd == 0 && st > 0) begin
                    st--;
                end else begin
                    mem_req_ready = 1'b1;
                    pend  = 1'b1;
                    pdata = (nrd == 0) ? l0 : l1;
                    nrd++;
                end
            end
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        if (lat > 0) begin
            @(negedge clk);
            pulse1 = (resp_valid === 1'b0) && (req_ready === 1'b1);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        req_valid      = 1'b0;
        vpn            = '0;
        ptbr           = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (3) @(negedge clk);
        req_valid = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req_ready);
        else n_pass++;
        n_total++;
        if (mem_req_valid !== 1'b0) $display("FAIL rst_memreq got %b want 0", mem_req_valid);
        else n_pass++;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL rst_resp got %b want 0", resp_valid);
        else n_pass++;
        n_total++;
        if (resp_err !== 1'b0) $display("FAIL rst_err got %b want 0", resp_err);
        else n_pass++;
        n_total++;
        if (resp_ppn !== 32'h0) $display("FAIL rst_ppn got %h want 0", resp_ppn);
        else n_pass++;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_two_level();
        int lat; int nrd; logic err; logic [31:0] ppn, a0, a1; bit st, pl;
        do_walk(32'h80, 20'h00403, 32'h00024001, 32'h048D1403, 0, 0,
                lat, err, ppn, a0, a1, nrd, st, pl);
        n_total++;
        if (lat !== 5) $display("FAIL two_lat got %0d want 5", lat);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL two_err got %b want 0", err);
        else n_pass++;
        n_total++;
        if (ppn !== 32'h00012345) $display("FAIL two_ppn got %h want 00012345", ppn);
        else n_pass++;
        n_total++;
        if (a0 !== 32'h00080004) $display("FAIL two_a0 got %h want 00080004", a0);
        else n_pass++;
        n_total++;
        if (a1 !== 32'h0009000C) $display("FAIL two_a1 got %h want 0009000c", a1);
        else n_pass++;
        n_total++;
        if (nrd !== 2) $display("FAIL two_reads got %0d want 2", nrd);
        else n_pass++;
        n_total++;
        if (pl !== 1'b1) $display("FAIL two_pulse got %b want 1", pl);
        else n_pass++;
    endtask

    task automatic test_superpage();
        int lat; int nrd; logic err; logic [31:0] ppn, a0, a1; bit st, pl;
        do_walk(32'h80, 20'h00403, 32'h00300003, 32'h048D1403, 0, 0,
                lat, err, ppn, a0, a1, nrd, st, pl);
        n_total++;
        if (lat !== 3) $display("FAIL sp_lat got %0d want 3", lat);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL sp_err got %b want 0", err);
        else n_pass++;
        n_total++;
        if (ppn !== 32'h00000C03) $display("FAIL sp_ppn got %h want 00000c03", ppn);
        else n_pass++;
        n_total++;
        if (nrd !== 1) $display("FAIL sp_reads got %0d want 1", nrd);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        int lat; int nrd; logic err; logic [31:0] ppn, a0, a1; bit st, pl;
        do_walk(32'h80, 20'h00403, 32'h00300403, 32'h048D1403, 0, 0,
                lat, err, ppn, a0, a1, nrd, st, pl);
        n_total++;
        if (lat !== 3) $display("FAIL mis_lat got %0d want 3", lat);
        else n_pass++;
        n_total++;
        if (err !== 1'b1) $display("FAIL mis_err got %b want 1", err);
        else n_pass++;
        n_total++;
        if (ppn !== 32'h0) $display("FAIL mis_ppn got %h want 0", ppn);
        else n_pass++;
    endtask

    task automatic test_faults();
        int lat; int nrd; logic err; logic [31:0] ppn, a0, a1; bit st, pl;
        do_walk(32'h80, 20'h00403, 32'h00000000, 32'h048D1403, 0, 0,
                lat, err, ppn, a0, a1, nrd, st, pl);
        n_total++;
        if (lat !== 3) $display("FAIL f0_lat got %0d want 3", lat);
        else n_pass++;
        n_total++;
        if (err !== 1'b1) $display("FAIL f0_err got %b want 1", err);
        else n_pass++;
        n_total++;
        if (ppn !== 32'h0) $display("FAIL f0_ppn got %h want 0", ppn);
        else n_pass++;
        do_walk(32'h80, 20'h00403, 32'h00024001, 32'h00024001, 0, 0,
                lat, err, ppn, a0, a1, nrd, st, pl);
        n_total++;
        if (lat !== 5) $display("FAIL f1_lat got %0d want 5", lat);
        else n_pass++;
        n_total++;
        if (err !== 1'b1) $display("FAIL f1_err got %b want 1", err);
        else n_pass++;
        n_total++;
        if (ppn !== 32'h0) $display("FAIL f1_ppn got %h want 0", ppn);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int lat; int nrd; logic err; logic [31:0] ppn, a0, a1; bit st, pl;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0;
        @(negedge clk);
        do_walk(32'h80, 20'h00403, 32'h00024001, 32'h048D1403, 4, 2,
                lat, err, ppn, a0, a1, nrd, st, pl);
        n_total++;
        if (lat !== 9) $display("FAIL bp_lat got %0d want 9", lat);
        else n_pass++;
        n_total++;
        if (st !== 1'b1) $display("FAIL bp_addr_stable got %b want 1", st);
        else n_pass++;
        n_total++;
        if (a0 !== 32'h00080004) $display("FAIL bp_a0 got %h want 00080004", a0);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL bp_err got %b want 0", err);
        else n_pass++;
        n_total++;
        if (ppn !== 32'h00012345) $display("FAIL bp_ppn got %h want 00012345", ppn);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; int nrd; logic err; logic [31:0] ppn, a0, a1; bit st, pl;
        do_walk(32'h100, 20'h00805, 32'h00024001, 32'h00400C03, 0, 0,
                lat, err, ppn, a0, a1, nrd, st, pl);
        n_total++;
        if (a0 !== 32'h00100008) $display("FAIL b2b_a0 got %h want 00100008", a0);
        else n_pass++;
        n_total++;
        if (a1 !== 32'h00090014) $display("FAIL b2b_a1 got %h want 00090014", a1);
        else n_pass++;
        n_total++;
        if (ppn !== 32'h00001003) $display("FAIL b2b_ppn1 got %h want 00001003", ppn);
        else n_pass++;
        do_walk(32'h80, 20'h00403, 32'h00300003, 32'h0, 0, 0,
                lat, err, ppn, a0, a1, nrd, st, pl);
        n_total++;
        if (lat !== 3) $display("FAIL b2b_lat2 got %0d want 3", lat);
        else n_pass++;
        n_total++;
        if (ppn !== 32'h00000C03) $display("FAIL b2b_ppn2 got %h want 00000c03", ppn);
        else n_pass++;
    endtask

    task automatic test_reset_wait1();
        int lat; int nrd; logic err; logic [31:0] ppn, a0, a1; bit st, pl;
        req_valid = 1'b1;
        vpn       = 20'h00403;
        ptbr      = 32'h80;
        @(negedge clk);
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h00024001;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        n_total++;
        if (mem_req_valid !== 1'b0) $display("FAIL rw1_memreq got %b want 0", mem_req_valid);
        else n_pass++;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL rw1_resp got %b want 0", resp_valid);
        else n_pass++;
        n_total++;
        if (req_ready !== 1'b0) $display("FAIL rw1_ready_in_rst got %b want 0", req_ready);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL rw1_idle got %b want 1", req_ready);
        else n_pass++;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL rw1_no_pulse got %b want 0", resp_valid);
        else n_pass++;
        do_walk(32'h80, 20'h00403, 32'h00024001, 32'h048D1403, 0, 0,
                lat, err, ppn, a0, a1, nrd, st, pl);
        n_total++;
        if (lat !== 5) $display("FAIL rw1_lat got %0d want 5", lat);
        else n_pass++;
        n_total++;
        if (ppn !== 32'h00012345) $display("FAIL rw1_ppn got %h want 00012345", ppn);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_two_level();
        test_superpage();
        test_misaligned();
        test_faults();
        test_backpressure();
        test_back_to_back();
        test_reset_wait1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
